// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOADED,
    TX_START,
    TX_DATA,
    TX_NINTH,
    TX_STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// PIC16F-style asynchronous USART transmitter: TXREG buffer, 9-bit TSR and a
// bit-strobed frame FSM producing a registered, LSB-first TX line.
module uart_tx
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spen,
  input  logic                      txen,
  input  logic                      tx9,
  input  logic                      tx9d,
  input  logic                      txreg_wr_en,
  input  logic [UART_DATA_BITS-1:0] txreg_in,
  input  logic                      tx_shift_en,
  output logic                      tx_pin,
  output logic                      txif,
  output logic                      trmt
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t              r_state;
  logic [UART_DATA_BITS-1:0]   r_txreg;
  logic                        r_txreg_full;
  logic [UART_DATA_BITS:0]     r_tsr;
  logic                        r_frame9;
  logic [2:0]                  r_bit_idx;
  logic                        r_tx_pin;

  uart_tx_state_t              w_state_next;
  logic [2:0]                  w_bit_idx_next;
  logic                        w_load;
  logic [UART_DATA_BITS:0]     w_tsr_next;
  logic                        w_frame9_next;
  logic                        w_line_next;

  // Frame sequencing: next state, bit index and TXREG->TSR transfer request.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_load         = 1'b0;
    if (!txen) begin
      // Disabling the transmitter aborts the frame; the buffer is left alone.
      w_state_next   = TX_IDLE;
      w_bit_idx_next = 3'd0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (r_txreg_full) begin
            w_load       = 1'b1;
            w_state_next = TX_LOADED;
          end
        end
        TX_LOADED: begin
          if (tx_shift_en) w_state_next = TX_START;
        end
        TX_START: begin
          if (tx_shift_en) begin
            w_state_next   = TX_DATA;
            w_bit_idx_next = 3'd0;
          end
        end
        TX_DATA: begin
          if (tx_shift_en) begin
            if (r_bit_idx == LAST_IDX) begin
              w_bit_idx_next = 3'd0;
              w_state_next   = r_frame9 ? TX_NINTH : TX_STOP;
            end else begin
              w_bit_idx_next = r_bit_idx + 3'd1;
            end
          end
        end
        TX_NINTH: begin
          if (tx_shift_en) w_state_next = TX_STOP;
        end
        TX_STOP: begin
          if (tx_shift_en) begin
            // A byte already waiting is chained straight into a new start bit.
            if (r_txreg_full) begin
              w_load       = 1'b1;
              w_state_next = TX_START;
            end else begin
              w_state_next = TX_IDLE;
            end
          end
        end
        default: w_state_next = TX_IDLE;
      endcase
    end
  end

  // Shift register contents and frame-width flag as they will be after this edge.
  always_comb begin
    w_tsr_next    = w_load ? {tx9d, r_txreg} : r_tsr;
    w_frame9_next = w_load ? tx9 : r_frame9;
  end

  // Line level belonging to the upcoming state, so the pin changes on the strobe edge.
  always_comb begin
    w_line_next = UART_IDLE_LEVEL;
    case (w_state_next)
      TX_START: w_line_next = 1'b0;
      TX_DATA:  w_line_next = w_tsr_next[w_bit_idx_next];
      TX_NINTH: w_line_next = w_tsr_next[UART_DATA_BITS];
      default:  w_line_next = UART_IDLE_LEVEL;
    endcase
  end

  // FSM state, shifter and registered TX pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_bit_idx <= 3'd0;
      r_tsr     <= '0;
      r_frame9  <= 1'b0;
      r_tx_pin  <= UART_IDLE_LEVEL;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_tsr     <= w_tsr_next;
      r_frame9  <= w_frame9_next;
      r_tx_pin  <= spen ? w_line_next : UART_IDLE_LEVEL;
    end
  end

  // TXREG buffer: a write in the transfer cycle refills it, so the write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txreg      <= '0;
      r_txreg_full <= 1'b0;
    end else begin
      if (w_load) r_txreg_full <= 1'b0;
      if (txreg_wr_en) begin
        r_txreg      <= txreg_in;
        r_txreg_full <= 1'b1;
      end
    end
  end

  assign tx_pin = r_tx_pin;
  assign txif   = ~r_txreg_full;
  assign trmt   = (r_state == TX_IDLE);

endmodule
